fetch_issue_unit: RTL

- Front-end stage that produces the decoder-side inputs (Instruction, Stall, Jumpp) consumed by the control unit.
- Holds the PC and fetches from instruction memory through a valid handshake.
- Registers the IF/ID instruction and PC, detects load-use hazards, and squashes wrong-path slots after a redirect.
- Drains and halts the front end on an ecall/ebreak halt request.

---
 rtl/fetch_issue_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_issue_unit.sv
// Front-end fetch stage: PC, IF/ID register, load-use stall detection,
// post-redirect squashing and ecall/ebreak drain-to-halt sequencing.
module fetch_issue_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_SLOTS  = 1,
    parameter int              DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            halt_req,
    output logic [31:0]     Instruction,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            Stall,
    output logic            Jumpp,
    output logic            halted
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI     = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC   = 7'b0010111;
    localparam logic [6:0]  OP_JAL     = 7'b1101111;
    localparam logic [6:0]  OP_RTYPE   = 7'b0110011;
    localparam logic [6:0]  OP_STORE   = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
    localparam logic [1:0]  SQ_INIT    = 2'(FLUSH_SLOTS - 1);
    localparam logic [2:0]  DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALT_DRAIN = 2'd1,
        HALTED     = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] id_pc_d;
    logic            id_valid, id_valid_d;
    logic [1:0]      squash_cnt, squash_d;
    logic [2:0]      drain_cnt, drain_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic       unused_target_lsb;

    assign unused_target_lsb = &{1'b0, redirect_target[1:0]};

    assign opcode   = Instruction[6:0];
    assign rs1      = Instruction[19:15];
    assign rs2      = Instruction[24:20];
    assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC ||
                        opcode == OP_JAL);
    assign rs2_used = (opcode == OP_RTYPE || opcode == OP_STORE ||
                       opcode == OP_BRANCH);

    assign Stall = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   ((rs1_used && ex_rd == rs1) ||
                    (rs2_used && ex_rd == rs2));

    assign imem_addr   = pc;
    assign id_pc_plus4 = id_pc + XLEN'(4);
    assign Jumpp       = ~id_valid;
    assign halted      = (state == HALTED);

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        instr_d    = Instruction;
        id_pc_d    = id_pc;
        id_valid_d = id_valid;
        squash_d   = squash_cnt;
        drain_d    = drain_cnt;
        unique case (state)
            RUN: begin
                if (halt_req) begin
                    state_d    = HALT_DRAIN;
                    drain_d    = '0;
                    instr_d    = NOP;
                    id_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    pc_d       = {redirect_target[XLEN-1:2], 2'b00};
                    instr_d    = NOP;
                    id_valid_d = 1'b0;
                    squash_d   = SQ_INIT;
                end else if (Stall) begin
                    // hold pc and IF/ID until the load leaves EX
                end else if (!imem_valid) begin
                    instr_d    = NOP;
                    id_valid_d = 1'b0;
                end else begin
                    pc_d    = pc + XLEN'(4);
                    id_pc_d = pc;
                    if (squash_cnt != 2'd0) begin
                        squash_d   = squash_cnt - 2'd1;
                        instr_d    = NOP;
                        id_valid_d = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        id_valid_d = 1'b1;
                    end
                end
            end
            HALT_DRAIN: begin
                instr_d    = NOP;
                id_valid_d = 1'b0;
                if (drain_cnt == DRAIN_LAST) state_d = HALTED;
                else drain_d = drain_cnt + 3'd1;
            end
            HALTED: begin
                id_valid_d = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            Instruction <= NOP;
            id_pc       <= '0;
            id_valid    <= 1'b0;
            squash_cnt  <= '0;
            drain_cnt   <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            Instruction <= instr_d;
            id_pc       <= id_pc_d;
            id_valid    <= id_valid_d;
            squash_cnt  <= squash_d;
            drain_cnt   <= drain_d;
        end
    end

endmodule
